// File: rtl/fp_divider.sv
// Multi-cycle binary32 divider: radix-2 restoring mantissa loop, RNE rounding.
// Optional macro FP_DIV_SPECIAL_BYPASS_EN sends special-case operands IDLE -> DONE.
module fp_divider (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    ROUND,
    DONE
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [25:0] rem_q;
  logic [25:0] quo_q;
  logic [31:0] y_q;
  logic        dz_q;
  logic        in_ready_q;
  logic        out_valid_q;

  // {hit, div_by_zero, y}; hit=0 means the normal path applies
  function automatic logic [33:0] special_f(
    input logic [31:0] x,
    input logic [31:0] z
  );
    logic       s;
    logic       xn, xi, xz;
    logic       zn, zi, zz;
    logic [33:0] r;
    s  = x[31] ^ z[31];
    xn = (&x[30:23]) & (|x[22:0]);
    xi = (&x[30:23]) & ~(|x[22:0]);
    xz = ~(|x[30:23]);
    zn = (&z[30:23]) & (|z[22:0]);
    zi = (&z[30:23]) & ~(|z[22:0]);
    zz = ~(|z[30:23]);
    r  = {2'b00, s, 31'd0};
    if (xn | zn | (xz & zz) | (xi & zi))
      r = {2'b10, s, 8'hFF, 23'h400000};
    else if (xi)
      r = {2'b10, s, 8'hFF, 23'd0};
    else if (zi)
      r = {2'b10, s, 31'd0};
    else if (xz)
      r = {2'b10, s, 31'd0};
    else if (zz)
      r = {2'b11, s, 8'hFF, 23'd0};
    return r;
  endfunction

  logic [33:0] sp_q;
  assign sp_q = special_f(a_q, b_q);

`ifdef FP_DIV_SPECIAL_BYPASS_EN
  logic [33:0] sp_in;
  assign sp_in = special_f(a, b);
`endif

  logic [25:0] mb;
  logic        ge;
  logic [25:0] rem_sub;
  logic [25:0] rem_d;
  logic [25:0] quo_d;

  assign mb = {3'b001, b_q[22:0]};

  always_comb begin
    ge      = rem_q >= mb;
    rem_sub = ge ? rem_q - mb : rem_q;
    rem_d   = rem_sub << 1;
    quo_d   = {quo_q[24:0], ge};
  end

  logic signed [9:0] exp_base;
  logic signed [9:0] e0;
  logic signed [9:0] e1;
  logic [22:0] man;
  logic [22:0] man_r;
  logic        g;
  logic        st;
  logic        rup;
  logic        carry;
  logic        sgn;
  logic [31:0] norm_y;

  assign sgn = a_q[31] ^ b_q[31];
  assign exp_base = signed'({2'b00, a_q[30:23]})
                  - signed'({2'b00, b_q[30:23]})
                  + 10'sd127;

  always_comb begin
    if (quo_q[25]) begin
      man = quo_q[24:2];
      g   = quo_q[1];
      st  = (|rem_q) | quo_q[0];
      e0  = exp_base;
    end else begin
      man = quo_q[23:1];
      g   = quo_q[0];
      st  = |rem_q;
      e0  = exp_base - 10'sd1;
    end
    rup = g & (st | man[0]);
    {carry, man_r} = {1'b0, man} + {23'd0, rup};
    e1 = e0 + signed'({9'd0, carry});
    if (e1 >= 10'sd255)
      norm_y = {sgn, 8'hFF, 23'd0};
    else if (e1 <= 10'sd0)
      norm_y = {sgn, 31'd0};
    else
      norm_y = {sgn, e1[7:0], man_r};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      rem_q       <= 26'd0;
      quo_q       <= 26'd0;
      y_q         <= 32'd0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            rem_q      <= {3'b001, a[22:0]};
            quo_q      <= 26'd0;
            cnt_q      <= 5'd0;
            in_ready_q <= 1'b0;
`ifdef FP_DIV_SPECIAL_BYPASS_EN
            if (sp_in[33]) begin
              y_q         <= sp_in[31:0];
              dz_q        <= sp_in[32];
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= DIV;
            end
`else
            state_q <= DIV;
`endif
          end
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == 5'd25) begin
            cnt_q   <= 5'd0;
            state_q <= ROUND;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        ROUND: begin
          if (sp_q[33]) begin
            y_q  <= sp_q[31:0];
            dz_q <= sp_q[32];
          end else begin
            y_q  <= norm_y;
            dz_q <= 1'b0;
          end
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign y           = y_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_fp_divider.sv
// Bench for fp_divider: directed cases, backpressure, reset, random vs model.
// Latency expectation follows FP_DIV_SPECIAL_BYPASS_EN when defined.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] y;
  logic        div_by_zero;

  int total = 0;
  int bad = 0;

  fp_divider dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference: exact quotient via wide integer division, then RNE to 24 bits
  function automatic logic [33:0] ref_div(input logic [31:0] x,
                                          input logic [31:0] z);
    logic s;
    int ex, ez, e, sh;
    longint unsigned mx, mz, num, qq, rr, sig, low, half;
    bit xn, xi, xz, zn, zi, zz, rup;
    s  = x[31] ^ z[31];
    ex = int'(x[30:23]);
    ez = int'(z[30:23]);
    xn = (ex == 255) && (x[22:0] != 0);
    xi = (ex == 255) && (x[22:0] == 0);
    xz = (ex == 0);
    zn = (ez == 255) && (z[22:0] != 0);
    zi = (ez == 255) && (z[22:0] == 0);
    zz = (ez == 0);
    if (xn || zn || (xz && zz) || (xi && zi)) return {2'b10, s, 31'h7FC00000};
    if (xi) return {2'b10, s, 31'h7F800000};
    if (zi) return {2'b10, s, 31'd0};
    if (xz) return {2'b10, s, 31'd0};
    if (zz) return {2'b11, s, 31'h7F800000};
    mx  = 64'(x[22:0]) | (64'd1 << 23);
    mz  = 64'(z[22:0]) | (64'd1 << 23);
    num = mx << 40;
    qq  = num / mz;
    rr  = num % mz;
    e   = ex - ez + 127;
    if (qq >= (64'd1 << 40)) sh = 17;
    else begin
      sh = 16;
      e  = e - 1;
    end
    sig  = qq >> sh;
    low  = qq & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    rup  = (low > half) || ((low == half) && ((rr != 0) || sig[0]));
    sig  = sig + 64'(rup);
    if (sig == (64'd1 << 24)) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    if (e >= 255) return {2'b00, s, 31'h7F800000};
    if (e <= 0) return {2'b00, s, 31'd0};
    return {2'b00, s, 8'(e), sig[22:0]};
  endfunction

  task automatic run(input string tag, input logic [31:0] ta,
                     input logic [31:0] tb_v, input int stall,
                     input logic [31:0] ey, input logic edz);
    logic [33:0] m;
    int n;
    int exp_lat;
    m = ref_div(ta, tb_v);
`ifdef FP_DIV_SPECIAL_BYPASS_EN
    exp_lat = m[33] ? 1 : 28;
`else
    exp_lat = 28;
`endif
    @(negedge clk);
    chk({tag, ".rdy"}, {31'd0, in_ready}, 32'd1);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, ".lat"}, n, exp_lat);
    chk({tag, ".y"}, y, ey);
    chk({tag, ".dz"}, {31'd0, div_by_zero}, {31'd0, edz});
    chk({tag, ".busy"}, {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      in_valid = i[0];
      a = $urandom;
      b = $urandom;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk({tag, ".hold_y"}, y, ey);
      chk({tag, ".hold_v"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".hold_r"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".done_v"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".done_r"}, {31'd0, in_ready}, 32'd1);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    logic [7:0] e;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) e = 8'($urandom_range(0, 255));
    else e = 8'($urandom_range(110, 145));
    r[30:23] = e;
    return r;
  endfunction

  initial begin
    logic [33:0] m;
    logic [31:0] x, z;
    reset_n = 1'b0;
    #12;
    chk("rst.rdy", {31'd0, in_ready}, 32'd1);
    chk("rst.val", {31'd0, out_valid}, 32'd0);
    chk("rst.y", y, 32'd0);
    chk("rst.dz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run("six_two", 32'h40C00000, 32'h40000000, 0, 32'h40400000, 1'b0);
    run("third", 32'h3F800000, 32'h40400000, 10, 32'h3EAAAAAB, 1'b0);
    run("one_one", 32'h3F800000, 32'h3F800000, 0, 32'h3F800000, 1'b0);
    run("dz", 32'h3F800000, 32'h00000000, 0, 32'h7F800000, 1'b1);
    run("zz", 32'h00000000, 32'h00000000, 0, 32'h7FC00000, 1'b0);
    run("infinf", 32'hFF800000, 32'h7F800000, 0, 32'hFFC00000, 1'b0);
    run("inf_fin", 32'h7F800000, 32'hC0000000, 0, 32'hFF800000, 1'b0);
    run("fin_inf", 32'h40000000, 32'h7F800000, 0, 32'h00000000, 1'b0);
    run("nan", 32'h7FC00001, 32'h3F800000, 0, 32'h7FC00000, 1'b0);
    run("subn_a", 32'h80000123, 32'h3F800000, 0, 32'h80000000, 1'b0);
    run("ovf", 32'h7F000000, 32'h3E800000, 0, 32'h7F800000, 1'b0);
    run("udf", 32'h00800000, 32'h40000000, 0, 32'h00000000, 1'b0);

    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst.val", {31'd0, out_valid}, 32'd0);
    chk("midrst.rdy", {31'd0, in_ready}, 32'd1);
    chk("midrst.y", y, 32'd0);
    chk("midrst.dz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run("after_rst", 32'h40C00000, 32'h40000000, 0, 32'h40400000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      x = rnd_op();
      z = rnd_op();
      m = ref_div(x, z);
      run("rnd", x, z, 0, m[31:0], m[32]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_divider.md
# fp_divider

Multi-cycle IEEE-754 single-precision divider (y = a / b) for the vector coprocessor's floating-point functional-unit set; it is the inverse-operation companion to the combinational FP multiplier. It computes one quotient at a time with a radix-2 restoring mantissa iteration. Valid/ready handshakes on both sides let the lane sequencer stall it without losing data.

## Interface
- No parameters; the format is fixed at binary32.
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  divider idle and able to accept
- a  input  32  dividend, binary32
- b  input  32  divisor, binary32
- out_valid  output  1  result y valid
- out_ready  input  1  consumer accepts y
- y  output  32  quotient, binary32
- div_by_zero  output  1  flag valid with y: finite nonzero a, zero b

## Operation
- Accept: in_valid & in_ready at a rising edge. a and b are latched; in_ready drops.
- Inputs with exponent 0 are treated as signed zero (subnormals flushed). Output sign = a[31]^b[31] in all cases.
- Special cases, in priority order:
  - a or b NaN, 0/0, or inf/inf -> {sign,8'hFF,23'h400000}
  - inf/finite -> {sign,8'hFF,0}
  - finite/inf -> {sign,8'h00,0}
  - a zero (b nonzero) -> {sign,8'h00,0}
  - nonzero finite / zero -> {sign,8'hFF,0} and div_by_zero=1
- Normal path:
  - Mantissas ma={1,a[22:0]} and mb={1,b[22:0]}.
  - 26 restoring iterations produce quotient q[25:0], an integer bit plus 25 fractional bits.
  - sticky = remainder != 0.
- Normalise:
  - If q[25]=1, use mantissa q[24:2], guard q[1], sticky |= q[0].
  - Otherwise use mantissa q[23:1], guard q[0], and decrement the exponent by 1.
- Exponent: a 10-bit signed value, e = ea - eb + 127 (minus the normalise adjust).
- Rounding: round-to-nearest-even; round up when guard & (sticky | lsb). A mantissa carry increments e.
- Overflow: e >= 255 after rounding -> {sign,8'hFF,0}.
- Underflow: e <= 0 -> {sign,8'h00,0}, flushed with no subnormal output.
- States:
  - IDLE: in_ready=1. Accept -> DIV, or -> DONE when bypassing.
  - DIV: a 5-bit counter runs 0..25. When count = 25 -> ROUND.
  - ROUND: registers y and div_by_zero -> DONE.
  - DONE: out_valid=1. If out_ready -> IDLE.

## Timing
- Reset values: in_ready=1, out_valid=0, y=0, div_by_zero=0, state=IDLE, counter=0.
- Normal-path latency: out_valid asserts 28 rising edges after the accepting edge (26 DIV + 1 ROUND + 1 DONE entry).
- in_ready=0 from the accepting edge until the edge where out_valid&out_ready completes. There is no overlap between a result and the next operand; throughput is 1 per 29 cycles minimum.
- y and div_by_zero stay stable while out_valid=1 and out_ready=0, for an unbounded time.
- in_valid asserted while in_ready=0 is ignored; operands are not queued.
- reset_n low at any cycle, including mid-DIV or while in DONE: all outputs return to their reset values immediately; the in-flight operation is discarded.
- Special-case inputs without FP_DIV_SPECIAL_BYPASS_EN run the full 28-cycle path; the result is forced in ROUND.

## Configuration
- FP_DIV_SPECIAL_BYPASS_EN defined:
  - Special-case operands (NaN, inf, zero, flushed subnormal) go IDLE -> DONE directly.
  - out_valid asserts 1 edge after accept.
- Undefined: every operation takes the fixed 28-cycle latency. This gives deterministic timing for the lane scheduler.
- Results are identical in both builds; only latency differs.

## Test plan
- a=0x40C00000 (6.0), b=0x40000000 (2.0), out_ready=1 -> y=0x40400000 exactly 28 edges after accept; in_ready returns to 1 the following cycle.
- a=0x3F800000, b=0x40400000 (1/3) -> y=0x3EAAAAAB, which exercises round-up; a=0x3F800000, b=0x3F800000 -> 0x3F800000.
- Special cases:
  - a=0x3F800000, b=0x00000000 -> y=0x7F800000 with div_by_zero=1.
  - 0/0 -> 0x7FC00000, div_by_zero=0.
  - a=0xFF800000, b=0x7F800000 -> 0xFFC00000.
  - Latency is 1 edge with FP_DIV_SPECIAL_BYPASS_EN and 28 edges without.
- Range limits:
  - a=0x7F000000, b=0x3E800000 -> 0x7F800000 (overflow).
  - a=0x00800000, b=0x40000000 -> 0x00000000 (underflow flush).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> y stays stable and in_ready stays 0; in_valid pulses during the stall are ignored; the result completes on the out_ready edge.
- Reset mid-operation: assert reset_n=0 at DIV count 12 -> out_valid=0 and in_ready=1 immediately. After release, a fresh 6.0/2.0 returns 0x40400000 with the normal latency.
